// File: rtl/acl_avg.sv
// Box-car averager: sums 2^LOG2_N X/Y/Z samples and emits 5-bit sign-magnitude results.
// Optional macro ACL_AVG_DEADBAND_EN forces magnitudes <= 1 to zero.
module acl_avg #(
  parameter int unsigned LOG2_N = 3,
  parameter int unsigned SHIFT  = 4
) (
  input  logic        clk_8mhz,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [11:0] in_x,
  input  logic [11:0] in_y,
  input  logic [11:0] in_z,
  output logic [4:0]  x,
  output logic [4:0]  y,
  output logic [4:0]  z,
  output logic        out_valid
);

  localparam int unsigned AW = 12 + LOG2_N;
  localparam int unsigned Sh = LOG2_N + SHIFT;
  localparam logic [LOG2_N-1:0] CntMax = '1;
  localparam logic [AW-1:0] MaxMag = AW'(15);

  logic signed [AW-1:0] acc_q [3];
  logic signed [AW-1:0] acc_d [3];
  logic signed [AW-1:0] sum_q [3];
  logic signed [AW-1:0] sum_d [3];
  logic [4:0]           out_q [3];
  logic [4:0]           out_d [3];
  logic [LOG2_N-1:0]    cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 out_valid_q, out_valid_d;
  logic [11:0]          samp [3];

  assign samp[0] = in_x;
  assign samp[1] = in_y;
  assign samp[2] = in_z;

  function automatic logic signed [AW-1:0] sext(input logic [11:0] v);
    return $signed({{LOG2_N{v[11]}}, v});
  endfunction

  // Magnitude is taken as unsigned so the most negative sum stays exact.
  function automatic logic [4:0] to_sm(input logic signed [AW-1:0] s);
    logic [AW-1:0] abs_v;
    logic [AW-1:0] mag;
    logic [3:0]    m;
    abs_v = s[AW-1] ? (~s + AW'(1)) : s;
    mag   = abs_v >> Sh;
    m     = (mag > MaxMag) ? 4'd15 : mag[3:0];
`ifdef ACL_AVG_DEADBAND_EN
    if (m <= 4'd1) m = 4'd0;
`endif
    return {s[AW-1] && (m != 4'd0), m};
  endfunction

  always_comb begin
    acc_d       = acc_q;
    sum_d       = sum_q;
    out_d       = out_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    out_valid_d = 1'b0;
    if (in_valid) begin
      if (cnt_q == CntMax) begin
        for (int i = 0; i < 3; i++) begin
          sum_d[i] = acc_q[i] + sext(samp[i]);
          acc_d[i] = '0;
        end
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        for (int i = 0; i < 3; i++) acc_d[i] = acc_q[i] + sext(samp[i]);
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Stage 2 reads sum_q, which the next window cannot overwrite for >= 2 cycles.
    if (done_q) begin
      for (int i = 0; i < 3; i++) out_d[i] = to_sm(sum_q[i]);
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_8mhz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        acc_q[i] <= '0;
        sum_q[i] <= '0;
        out_q[i] <= '0;
      end
      cnt_q       <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        acc_q[i] <= acc_d[i];
        sum_q[i] <= sum_d[i];
        out_q[i] <= out_d[i];
      end
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign x         = out_q[0];
  assign y         = out_q[1];
  assign z         = out_q[2];
  assign out_valid = out_valid_q;

endmodule
